// File: rtl/d7s_pkg.sv
// Shared types, segment glyphs and the code-to-glyph decode function for the
// multiplexed 7-segment scan driver. Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package d7s_pkg;

    typedef logic [3:0] d7s_code_t;
    typedef logic [6:0] d7s_seg_t;

    localparam d7s_seg_t SEG_OFF    = 7'b0000000;
    localparam d7s_seg_t GLYPH_0    = 7'b0111111;
    localparam d7s_seg_t GLYPH_1    = 7'b0000110;
    localparam d7s_seg_t GLYPH_2    = 7'b1011011;
    localparam d7s_seg_t GLYPH_3    = 7'b1001111;
    localparam d7s_seg_t GLYPH_4    = 7'b1100110;
    localparam d7s_seg_t GLYPH_5    = 7'b1101101;
    localparam d7s_seg_t GLYPH_6    = 7'b1111101;
    localparam d7s_seg_t GLYPH_7    = 7'b0000111;
    localparam d7s_seg_t GLYPH_8    = 7'b1111111;
    localparam d7s_seg_t GLYPH_9    = 7'b1101111;
    localparam d7s_seg_t GLYPH_A    = 7'b1110111;
    localparam d7s_seg_t GLYPH_B    = 7'b1111100;
    localparam d7s_seg_t GLYPH_C    = 7'b0111001;
    localparam d7s_seg_t GLYPH_D    = 7'b1011110;
    localparam d7s_seg_t GLYPH_E    = 7'b1111001;
    localparam d7s_seg_t GLYPH_F    = 7'b1110001;
    localparam d7s_seg_t GLYPH_DASH = 7'b1000000;

    // Codes 10-15 render as hex letters or as a single dash depending on hex_mode.
    function automatic d7s_seg_t d7s_decode(input d7s_code_t code, input logic hex_mode);
        d7s_seg_t s;
        s = SEG_OFF;
        case (code)
            4'd0:    s = GLYPH_0;
            4'd1:    s = GLYPH_1;
            4'd2:    s = GLYPH_2;
            4'd3:    s = GLYPH_3;
            4'd4:    s = GLYPH_4;
            4'd5:    s = GLYPH_5;
            4'd6:    s = GLYPH_6;
            4'd7:    s = GLYPH_7;
            4'd8:    s = GLYPH_8;
            4'd9:    s = GLYPH_9;
            4'd10:   s = hex_mode ? GLYPH_A : GLYPH_DASH;
            4'd11:   s = hex_mode ? GLYPH_B : GLYPH_DASH;
            4'd12:   s = hex_mode ? GLYPH_C : GLYPH_DASH;
            4'd13:   s = hex_mode ? GLYPH_D : GLYPH_DASH;
            4'd14:   s = hex_mode ? GLYPH_E : GLYPH_DASH;
            default: s = hex_mode ? GLYPH_F : GLYPH_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/d7s_scan_mux_if.sv
// Bus between the display data source (master) and the scan driver (slave).
interface d7s_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 3
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_blank;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_tick;

    modport master (
        output load, bcd_in, dp_in, lz_blank,
        input  seg, dp, dig_en, frame_tick
    );

    modport slave (
        input  load, bcd_in, dp_in, lz_blank,
        output seg, dp, dig_en, frame_tick
    );
endinterface

// File: rtl/d7s_decoder.sv
// Combinational digit-code to active-high segment pattern decoder.
module d7s_decoder
    import d7s_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  d7s_code_t code_i,
    output d7s_seg_t  seg_o
);

    assign seg_o = d7s_decode(code_i, HEX_MODE);

endmodule

// File: rtl/d7s_scan_mux.sv
// N-digit multiplexed 7-segment driver: prescaled digit scan with a blanking guard
// at each slot start, double-buffered loads committed at frame wrap, leading-zero
// blanking and output polarity selection. All outputs are registered.
module d7s_scan_mux
    import d7s_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 3,
    parameter int unsigned CLK_DIV        = 1000,
    parameter int unsigned GUARD          = 16,
    parameter bit          HEX_MODE       = 1'b0,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input logic             clk,
    input logic             rst,
    d7s_scan_mux_if.slave   bus
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam d7s_seg_t              SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] act_bcd_q, act_bcd_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;

    d7s_seg_t                seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    tick_q, tick_d;

    logic                    slot_end;
    logic                    last_idx;
    logic                    commit;
    logic                    in_guard;
    logic [NUM_DIGITS-1:0]   lead_zero;
    d7s_code_t               cur_code;
    logic                    cur_dp;
    logic                    cur_lead;
    logic [NUM_DIGITS-1:0]   cur_onehot;
    logic                    blank;
    d7s_seg_t                dec_seg;

    assign slot_end = (pre_q == PW'(CLK_DIV - 1));
    assign last_idx = (idx_q == IW'(NUM_DIGITS - 1));
    assign commit   = slot_end && last_idx;
    assign in_guard = (int'(pre_q) < int'(GUARD));

    // Prescaler and digit-index advance.
    always_comb begin
        pre_d = slot_end ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = last_idx ? '0 : idx_q + 1'b1;
        end
    end

    // Double buffer: a load on the commit edge bypasses straight into the active copy.
    always_comb begin
        pend_bcd_d = bus.load ? bus.bcd_in : pend_bcd_q;
        pend_dp_d  = bus.load ? bus.dp_in  : pend_dp_q;
        act_bcd_d  = commit   ? pend_bcd_d : act_bcd_q;
        act_dp_d   = commit   ? pend_dp_d  : act_dp_q;
    end

    // Mark digits that sit in the run of zeros from the most significant end.
    always_comb begin : p_lead
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            run          = run && (act_bcd_q[4*i +: 4] == 4'd0);
            lead_zero[i] = run;
        end
    end

    // Select code, decimal point and blanking state for the digit being scanned.
    always_comb begin
        cur_code   = '0;
        cur_dp     = 1'b0;
        cur_lead   = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_code      = act_bcd_q[4*i +: 4];
                cur_dp        = act_dp_q[i];
                cur_lead      = lead_zero[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows a single 0.
    assign blank = bus.lz_blank && (idx_q != '0) && cur_lead;

    d7s_decoder #(
        .HEX_MODE (HEX_MODE)
    ) u_dec (
        .code_i (cur_code),
        .seg_o  (dec_seg)
    );

    // Next output values; polarity is applied only here at the register inputs.
    always_comb begin
        seg_d  = ((in_guard || blank) ? SEG_OFF : dec_seg) ^ SEG_INV;
        dp_d   = (!in_guard && cur_dp) ^ SEG_ACTIVE_LOW;
        dig_d  = (in_guard ? '0 : cur_onehot) ^ DIG_INV;
        tick_d = commit;
    end

    // State and registered outputs; reset forces every output to its inactive level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            idx_q      <= '0;
            pend_bcd_q <= '0;
            pend_dp_q  <= '0;
            act_bcd_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_OFF ^ SEG_INV;
            dp_q       <= SEG_ACTIVE_LOW;
            dig_q      <= DIG_INV;
            tick_q     <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            pend_bcd_q <= pend_bcd_d;
            pend_dp_q  <= pend_dp_d;
            act_bcd_q  <= act_bcd_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_q      <= dig_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.dig_en     = dig_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_d7s_scan_mux.sv
// Directed bench: three drivers (dash mode, hex mode, hex mode with inverted outputs)
// share one stimulus stream; expected values are hand-derived glyphs and scan timing.
module tb_d7s_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [11:0] bcd_in = '0;
    logic [2:0]  dp_in = '0;
    logic        lz_blank = 1'b0;

    int errors = 0;
    int checks = 0;
    int e = 0;

    logic [2:0] dig_tbl [12] = '{3'b000, 3'b001, 3'b001, 3'b001,
                                 3'b000, 3'b010, 3'b010, 3'b010,
                                 3'b000, 3'b100, 3'b100, 3'b100};

    always #5 clk = ~clk;

    d7s_scan_mux_if #(.NUM_DIGITS(3)) if0 ();
    d7s_scan_mux_if #(.NUM_DIGITS(3)) if1 ();
    d7s_scan_mux_if #(.NUM_DIGITS(3)) if2 ();

    assign if0.load = load;  assign if0.bcd_in = bcd_in;
    assign if0.dp_in = dp_in; assign if0.lz_blank = lz_blank;
    assign if1.load = load;  assign if1.bcd_in = bcd_in;
    assign if1.dp_in = dp_in; assign if1.lz_blank = lz_blank;
    assign if2.load = load;  assign if2.bcd_in = bcd_in;
    assign if2.dp_in = dp_in; assign if2.lz_blank = lz_blank;

    d7s_scan_mux #(
        .NUM_DIGITS(3), .CLK_DIV(4), .GUARD(1),
        .HEX_MODE(1'b0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    d7s_scan_mux #(
        .NUM_DIGITS(3), .CLK_DIV(4), .GUARD(1),
        .HEX_MODE(1'b1), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    d7s_scan_mux #(
        .NUM_DIGITS(3), .CLK_DIV(4), .GUARD(1),
        .HEX_MODE(1'b1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [2:0] dig, input logic [6:0] seg,
                        input logic dp);
        chk({tag, ".dig"}, 32'(if0.dig_en), 32'(dig));
        chk({tag, ".seg"}, 32'(if0.seg), 32'(seg));
        chk({tag, ".dp"}, 32'(if0.dp), 32'(dp));
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic step_to(input int n);
        while (e < n) step();
    endtask

    initial begin
        // Reset state, all three polarity/mode variants.
        repeat (2) @(posedge clk);
        #1;
        chk0("rst", 3'b000, 7'h00, 1'b0);
        chk("rst.tick", 32'(if0.frame_tick), 32'd0);
        chk("rst.inv.dig", 32'(if2.dig_en), 32'h7);
        chk("rst.inv.seg", 32'(if2.seg), 32'h7F);
        chk("rst.inv.dp", 32'(if2.dp), 32'h1);
        rst = 1'b0;
        e = 0;

        // First frame: scan timing and frame tick on the wrap edge.
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("scan.dig%0d", e), 32'(if0.dig_en), 32'(dig_tbl[i]));
            chk($sformatf("scan.tick%0d", e), 32'(if0.frame_tick), (e == 12) ? 32'd1 : 32'd0);
            if (e == 1) chk("scan.inv.idle", 32'(if2.dig_en), 32'h7);
            if (e == 2) begin
                chk("scan.inv.dig0", 32'(if2.dig_en), 32'h6);
                chk("scan.inv.seg0", 32'(if2.seg), 32'h40);
            end
        end

        // Load {1,2,3} dp=010 mid-frame; visible only after the next commit.
        load = 1'b1; bcd_in = {4'd1, 4'd2, 4'd3}; dp_in = 3'b010;
        step();
        load = 1'b0; bcd_in = 12'hFFF; dp_in = 3'b111;
        step_to(14); chk0("pre.d0", 3'b001, 7'h3F, 1'b0);
        step_to(18); chk0("pre.d1", 3'b010, 7'h3F, 1'b0);
        step_to(24); chk("commit1.tick", 32'(if0.frame_tick), 32'd1);
        step_to(26); chk0("ld.d0", 3'b001, 7'h4F, 1'b0);
        step_to(30); chk0("ld.d1", 3'b010, 7'h5B, 1'b1);
        step_to(34); chk0("ld.d2", 3'b100, 7'h06, 1'b0);

        // Tear-free: {4,5,6} mid-frame then {7,8,9} on the commit edge.
        step_to(40);
        load = 1'b1; bcd_in = {4'd4, 4'd5, 4'd6}; dp_in = 3'b000;
        step();
        load = 1'b0;
        step_to(42); chk0("tear.hold", 3'b010, 7'h5B, 1'b1);
        step_to(47);
        load = 1'b1; bcd_in = {4'd7, 4'd8, 4'd9}; dp_in = 3'b000;
        step();
        load = 1'b0; bcd_in = '0;
        chk0("tear.last", 3'b100, 7'h06, 1'b0);
        chk("tear.tick", 32'(if0.frame_tick), 32'd1);
        step_to(50); chk0("tear.d0", 3'b001, 7'h6F, 1'b0);
        step_to(54); chk0("tear.d1", 3'b010, 7'h7F, 1'b0);
        step_to(58); chk0("tear.d2", 3'b100, 7'h07, 1'b0);
        step_to(62); chk0("tear.again", 3'b001, 7'h6F, 1'b0);

        // Leading-zero blanking: {0,0,7} with dp on the blanked digit 2.
        lz_blank = 1'b1;
        step_to(64);
        load = 1'b1; bcd_in = {4'd0, 4'd0, 4'd7}; dp_in = 3'b100;
        step();
        load = 1'b0;
        step_to(74); chk0("lz007.d0", 3'b001, 7'h07, 1'b0);
        step_to(76);
        load = 1'b1; bcd_in = {4'd0, 4'd0, 4'd0}; dp_in = 3'b000;
        step();
        load = 1'b0;
        step_to(78); chk0("lz007.d1", 3'b010, 7'h00, 1'b0);
        step_to(82); chk0("lz007.d2", 3'b100, 7'h00, 1'b1);
        step_to(86); chk0("lz000.d0", 3'b001, 7'h3F, 1'b0);
        step_to(88);
        load = 1'b1; bcd_in = {4'd0, 4'd12, 4'd0}; dp_in = 3'b000;
        step();
        load = 1'b0;
        step_to(90); chk0("lz000.d1", 3'b010, 7'h00, 1'b0);
        step_to(94); chk0("lz000.d2", 3'b100, 7'h00, 1'b0);

        // {0,12,0}: code 12 counts as nonzero; mode and polarity variants.
        step_to(98);
        chk0("lzC0.d0", 3'b001, 7'h3F, 1'b0);
        chk("lzC0.inv.d0", 32'(if2.seg), 32'h40);
        step_to(102);
        chk0("lzC0.d1.dash", 3'b010, 7'h40, 1'b0);
        chk("lzC0.d1.hex", 32'(if1.seg), 32'h39);
        chk("lzC0.d1.inv", 32'(if2.seg), 32'h46);
        chk("lzC0.d1.invdig", 32'(if2.dig_en), 32'h5);
        step_to(106);
        chk0("lzC0.d2", 3'b100, 7'h00, 1'b0);
        chk("lzC0.d2.inv", 32'(if2.seg), 32'h7F);

        // Asynchronous reset while digit 2 is lit.
        rst = 1'b1;
        #1;
        chk0("amid", 3'b000, 7'h00, 1'b0);
        chk("amid.tick", 32'(if0.frame_tick), 32'd0);
        chk("amid.inv.dig", 32'(if2.dig_en), 32'h7);
        chk("amid.inv.seg", 32'(if2.seg), 32'h7F);
        chk("amid.inv.dp", 32'(if2.dp), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = 0;
        step_to(1); chk0("rel.guard", 3'b000, 7'h00, 1'b0);
        step_to(2); chk0("rel.d0", 3'b001, 7'h3F, 1'b0);
        step_to(6); chk0("rel.d1", 3'b010, 7'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
